// File: rtl/mul_arbiter_pkg.sv
// Shared types and defaults for the multiplier arbiter slice.
package mul_arbiter_pkg;

  localparam int DEF_WIDTH   = 10;
  localparam int DEF_NREQ    = 4;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Width of a requester index (at least one bit).
  function automatic int ptr_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_arbiter_if.sv
// Requester and multiplier signals of mul_arbiter.
// slave: the arbiter's view; master: the surrounding environment's view.
interface mul_arbiter_if #(
  parameter int WIDTH = mul_arbiter_pkg::DEF_WIDTH,
  parameter int NREQ  = mul_arbiter_pkg::DEF_NREQ
);

  // requester side
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a;
  logic [NREQ*WIDTH-1:0] b;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       rsp_valid;
  logic [2*WIDTH-1:0]    rsp_result;
  logic                  busy;
  logic                  timeout_err;

  // multiplier side
  logic                  mul_enable;
  logic [WIDTH-1:0]      mul_a;
  logic [WIDTH-1:0]      mul_b;
  logic                  mul_done;
  logic [2*WIDTH-1:0]    mul_result;

  modport slave (
    input  req, a, b, mul_done, mul_result,
    output gnt, rsp_valid, rsp_result, busy, timeout_err,
           mul_enable, mul_a, mul_b
  );

  modport master (
    output req, a, b, mul_done, mul_result,
    input  gnt, rsp_valid, rsp_result, busy, timeout_err,
           mul_enable, mul_a, mul_b
  );

endinterface

// File: rtl/mul_arbiter_rr_arbiter.sv
// Combinational round-robin selector: first set req bit at or above ptr,
// wrapping to the lowest set bit below ptr. Produces a one-hot winner.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic            found
);

  // Two-pass priority search: upper window first, then wrap from bit 0.
  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (PW'(i) >= ptr)) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: shares one external multiplier among NREQ requesters using
// round-robin arbitration and an IDLE/START/WAIT/RESP sequencer.
// Optional watchdog in WAIT is enabled by defining MUL_ARBITER_TIMEOUT_EN.
module mul_arbiter #(
  parameter int WIDTH   = mul_arbiter_pkg::DEF_WIDTH,
  parameter int NREQ    = mul_arbiter_pkg::DEF_NREQ,
  parameter int TIMEOUT = mul_arbiter_pkg::DEF_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst_n,
  mul_arbiter_if.slave bus
);

  import mul_arbiter_pkg::*;

  localparam int PW = ptr_width(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("mul_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
  end

  state_t             state;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      owner;
  logic [NREQ-1:0]    win_oh;
  logic               found;
  logic [PW-1:0]      win_idx;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic [NREQ-1:0]    gnt_q;
  logic [NREQ-1:0]    rsp_valid_q;
  logic [2*WIDTH-1:0] rsp_result_q;
  logic               mul_enable_q;
  logic [WIDTH-1:0]   mul_a_q;
  logic [WIDTH-1:0]   mul_b_q;
  logic               busy_q;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr (
    .req   (bus.req),
    .ptr   (ptr),
    .gnt   (win_oh),
    .found (found)
  );

  // Winner index and its operand pair, muxed from the packed buses.
  always_comb begin
    win_idx = '0;
    sel_a   = '0;
    sel_b   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win_oh[k]) begin
        win_idx = PW'(k);
        sel_a   = bus.a[k*WIDTH +: WIDTH];
        sel_b   = bus.b[k*WIDTH +: WIDTH];
      end
    end
  end

`ifdef MUL_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
  logic          timeout_q;
`endif

  // Sequencer: grant, start the multiplier, wait for its result, respond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      owner        <= '0;
      gnt_q        <= '0;
      rsp_valid_q  <= '0;
      // NOTE: operand/result registers are reset as well, because they drive outputs that must read 0 during reset.
      rsp_result_q <= '0;
      mul_enable_q <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      busy_q       <= 1'b0;
`ifdef MUL_ARBITER_TIMEOUT_EN
      wait_cnt     <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, whatever the statement order.
      gnt_q        <= '0;
      rsp_valid_q  <= '0;
      mul_enable_q <= 1'b0;
`ifdef MUL_ARBITER_TIMEOUT_EN
      timeout_q    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (found) begin
            mul_a_q <= sel_a;
            mul_b_q <= sel_b;
            owner   <= win_idx;
            gnt_q   <= win_oh;
            busy_q  <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          mul_enable_q <= 1'b1;
`ifdef MUL_ARBITER_TIMEOUT_EN
          wait_cnt     <= '0;
`endif
          state        <= WAIT;
        end
        WAIT: begin
          if (bus.mul_done) begin
            rsp_result_q <= bus.mul_result;
            state        <= RESP;
          end
`ifdef MUL_ARBITER_TIMEOUT_EN
          else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            rsp_result_q <= '0;
            timeout_q    <= 1'b1;
            state        <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          rsp_valid_q <= {{(NREQ-1){1'b0}}, 1'b1} << owner;
          ptr         <= (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.busy       = busy_q;
  assign bus.mul_enable = mul_enable_q;
  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
`ifdef MUL_ARBITER_TIMEOUT_EN
  assign bus.timeout_err = timeout_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed testbench for mul_arbiter (WIDTH=10, NREQ=4, TIMEOUT=64) with a
// behavioural multiplier whose done pulse can be delayed or withheld.
module tb_mul_arbiter;

  localparam int W  = 10;
  localparam int N  = 4;
  localparam int TO = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mul_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();

  mul_arbiter #(
    .WIDTH   (W),
    .NREQ    (N),
    .TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Behavioural multiplier: done pulse mul_lat+1 cycles after mul_enable.
  int unsigned    mul_lat     = 1;
  logic           hold_done   = 1'b0;
  logic           inject_done = 1'b0;
  logic           model_done;
  int unsigned    mcnt;
  logic [2*W-1:0] model_prod;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_done <= 1'b0;
      mcnt       <= 0;
      model_prod <= '0;
    end else begin
      model_done <= 1'b0;
      if (bus.mul_enable) begin
        mcnt       <= mul_lat;
        model_prod <= (2*W)'(bus.mul_a) * (2*W)'(bus.mul_b);
      end else if (mcnt != 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1 && !hold_done) model_done <= 1'b1;
      end
    end
  end

  assign bus.mul_done   = model_done | inject_done;
  assign bus.mul_result = inject_done ? 20'hABCDE : model_prod;

  // Sticky record of any watchdog pulse.
  logic to_seen;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)               to_seen <= 1'b0;
    else if (bus.timeout_err) to_seen <= 1'b1;
  end

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int k, input logic [W-1:0] av, input logic [W-1:0] bv);
    bus.req[k]         = 1'b1;
    bus.a[k*W +: W]    = av;
    bus.b[k*W +: W]    = bv;
  endtask

  // Waits (bounded) for a grant, checks it and the captured operands, then
  // advances to the mul_enable cycle.
  task automatic expect_grant(input string tag, input logic [N-1:0] exp_gnt,
                              input logic [W-1:0] ea, input logic [W-1:0] eb);
    int n = 0;
    while (bus.gnt == '0 && n < 12) begin
      tick();
      n++;
    end
    check({tag, ".gnt"},   32'(bus.gnt),   32'(exp_gnt));
    check({tag, ".mul_a"}, 32'(bus.mul_a), 32'(ea));
    check({tag, ".mul_b"}, 32'(bus.mul_b), 32'(eb));
    check({tag, ".busy"},  32'(bus.busy),  32'd1);
    tick();
    check({tag, ".enable"},  32'(bus.mul_enable), 32'd1);
    check({tag, ".gnt_off"}, 32'(bus.gnt),        32'd0);
  endtask

  // Waits (bounded) for the response and checks timing, owner and product.
  task automatic expect_rsp(input string tag, input logic [N-1:0] exp_valid,
                            input logic [2*W-1:0] exp_res, input int exp_wait);
    int n = 0;
    while (bus.rsp_valid == '0 && n < 200) begin
      tick();
      n++;
    end
    check({tag, ".wait"},   32'(n),              32'(exp_wait));
    check({tag, ".valid"},  32'(bus.rsp_valid),  32'(exp_valid));
    check({tag, ".result"}, 32'(bus.rsp_result), 32'(exp_res));
    check({tag, ".idle"},   32'(bus.busy),       32'd0);
  endtask

  initial begin
    int pulses;
    bus.req = '0;
    bus.a   = '0;
    bus.b   = '0;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.gnt",        32'(bus.gnt),         32'd0);
    check("rst.rsp_valid",  32'(bus.rsp_valid),   32'd0);
    check("rst.rsp_result", 32'(bus.rsp_result),  32'd0);
    check("rst.mul_enable", 32'(bus.mul_enable),  32'd0);
    check("rst.mul_a",      32'(bus.mul_a),       32'd0);
    check("rst.mul_b",      32'(bus.mul_b),       32'd0);
    check("rst.busy",       32'(bus.busy),        32'd0);
    check("rst.timeout",    32'(bus.timeout_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single request: 7*9 = 63, ptr -> 1
    drive_req(0, 10'd7, 10'd9);
    expect_grant("single", 4'b0001, 10'd7, 10'd9);
    bus.req[0] = 1'b0;
    expect_rsp("single", 4'b0001, 20'd63, 4);

    // Reset in the middle of WAIT with the multiplier silent
    drive_req(1, 10'd5, 10'd6);
    expect_grant("abort", 4'b0010, 10'd5, 10'd6);
    bus.req[1] = 1'b0;
    hold_done  = 1'b1;
`ifdef MUL_ARBITER_TIMEOUT_EN
    repeat (10) tick();
`else
    repeat (80) tick();
    check("nowdog.busy",    32'(bus.busy), 32'd1);
    check("nowdog.timeout", 32'(to_seen),  32'd0);
`endif
    rst_n = 1'b0;
    #1;
    check("abort.gnt",        32'(bus.gnt),         32'd0);
    check("abort.rsp_valid",  32'(bus.rsp_valid),   32'd0);
    check("abort.rsp_result", 32'(bus.rsp_result),  32'd0);
    check("abort.mul_enable", 32'(bus.mul_enable),  32'd0);
    check("abort.mul_a",      32'(bus.mul_a),       32'd0);
    check("abort.mul_b",      32'(bus.mul_b),       32'd0);
    check("abort.busy",       32'(bus.busy),        32'd0);
    check("abort.timeout",    32'(bus.timeout_err), 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    hold_done = 1'b0;
    pulses    = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.rsp_valid != '0 || bus.busy) pulses++;
    end
    check("abort.quiet", 32'(pulses), 32'd0);

    // Fairness from ptr=0 with all requests held: 0,1,2,3,0
    drive_req(0, 10'd3,    10'd5);
    drive_req(1, 10'd100,  10'd200);
    drive_req(2, 10'd1023, 10'd2);
    drive_req(3, 10'd12,   10'd12);
    expect_grant("fair0", 4'b0001, 10'd3, 10'd5);
    expect_rsp("fair0", 4'b0001, 20'd15, 4);
    expect_grant("fair1", 4'b0010, 10'd100, 10'd200);
    expect_rsp("fair1", 4'b0010, 20'd20000, 4);
    expect_grant("fair2", 4'b0100, 10'd1023, 10'd2);
    expect_rsp("fair2", 4'b0100, 20'd2046, 4);
    expect_grant("fair3", 4'b1000, 10'd12, 10'd12);
    expect_rsp("fair3", 4'b1000, 20'd144, 4);
    expect_grant("fair4", 4'b0001, 10'd3, 10'd5);
    bus.req = '0;
    expect_rsp("fair4", 4'b0001, 20'd15, 4);

    // Request rising in the return-to-IDLE cycle; maximum operands; ptr -> 3
    drive_req(2, 10'd1023, 10'd1023);
    tick();
    check("late.gnt", 32'(bus.gnt), 32'b0100);
    expect_grant("max", 4'b0100, 10'd1023, 10'd1023);
    bus.req[2] = 1'b0;
    expect_rsp("max", 4'b0100, 20'd1046529, 4);

    // Wrap: ptr=3, req=1001 -> 3 then 0; zero operand gives zero product
    drive_req(0, 10'd1, 10'd1);
    drive_req(3, 10'd0, 10'd500);
    expect_grant("wrap3", 4'b1000, 10'd0, 10'd500);
    bus.req[3] = 1'b0;
    expect_rsp("wrap3", 4'b1000, 20'd0, 4);
    expect_grant("wrap0", 4'b0001, 10'd1, 10'd1);
    bus.req[0] = 1'b0;
    expect_rsp("wrap0", 4'b0001, 20'd1, 4);

    // Stray mul_done while IDLE must change nothing
    tick();
    inject_done = 1'b1;
    tick();
    inject_done = 1'b0;
    check("stray.busy",  32'(bus.busy),      32'd0);
    check("stray.valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    check("stray.result", 32'(bus.rsp_result), 32'd1);
    check("stray.gnt",    32'(bus.gnt),        32'd0);

    // Withdrawn request raised and dropped while busy is never served
    drive_req(3, 10'd2, 10'd3);
    expect_grant("wd", 4'b1000, 10'd2, 10'd3);
    bus.req[3] = 1'b0;
    drive_req(1, 10'd9, 10'd9);
    tick();
    bus.req[1] = 1'b0;
    expect_rsp("wd", 4'b1000, 20'd6, 3);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.gnt != '0) pulses++;
    end
    check("wd.no_gnt", 32'(pulses), 32'd0);

`ifdef MUL_ARBITER_TIMEOUT_EN
    // Watchdog: done withheld -> pulse at WAIT cycle TO, then zero response
    hold_done = 1'b1;
    drive_req(2, 10'd4, 10'd4);
    expect_grant("to", 4'b0100, 10'd4, 10'd4);
    bus.req[2] = 1'b0;
    repeat (TO - 1) tick();
    check("to.early", 32'(bus.timeout_err), 32'd0);
    tick();
    check("to.pulse", 32'(bus.timeout_err), 32'd1);
    tick();
    check("to.valid",  32'(bus.rsp_valid),   32'b0100);
    check("to.result", 32'(bus.rsp_result),  32'd0);
    check("to.clear",  32'(bus.timeout_err), 32'd0);
    check("to.idle",   32'(bus.busy),        32'd0);
    hold_done = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time bound for the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter WIDTH, default 10: operand width; result is 2*WIDTH.
REQ-002 Parameter NREQ, default 4: number of requesters, range 2..8.
REQ-003 Parameter TIMEOUT, default 64: watchdog limit in cycles, used only under MUL_ARBITER_TIMEOUT_EN.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock; all logic rising-edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 req  in  NREQ  level request per requester.
REQ-008 a  in  NREQ*WIDTH  packed operand A; requester k at [k*WIDTH +: WIDTH].
REQ-009 b  in  NREQ*WIDTH  packed operand B, same packing.
REQ-010 gnt  out  NREQ  one-hot, one-cycle pulse when the winner's operands are captured.
REQ-011 rsp_valid  out  NREQ  one-hot, one-cycle pulse when the product is available.
REQ-012 rsp_result  out  2*WIDTH  shared product, valid when any rsp_valid bit is high.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 mul_enable  out  1  one-cycle start pulse to the external multiplier.
REQ-015 mul_a, mul_b  out  WIDTH each  operands to the multiplier.
REQ-016 mul_done  in  1  multiplier completion pulse.
REQ-017 mul_result  in  2*WIDTH  multiplier product, valid with mul_done.
REQ-018 timeout_err  out  1  one-cycle watchdog pulse; tied 0 without the macro.

Function
REQ-019 The FSM SHALL have four states: IDLE, START, WAIT and RESP.
REQ-020 IDLE, when any req bit is set: select a winner round-robin from pointer ptr, register its a/b into mul_a/mul_b, store it as owner, pulse gnt[owner], then go to START.
REQ-021 Round-robin: the winner is the first set req bit at or above ptr, wrapping modulo NREQ; a single requester is always granted.
REQ-022 START: assert mul_enable for exactly one cycle, then go to WAIT.
REQ-023 WAIT: on mul_done, register mul_result into rsp_result and go to RESP; otherwise stay in WAIT.
REQ-024 RESP: pulse rsp_valid[owner], set ptr to (owner+1) mod NREQ, then return to IDLE.
REQ-025 Best-case latency: gnt to rsp_valid = multiplier latency + 3 cycles; back-to-back grants are at least 4 cycles apart.
REQ-026 mul_a and mul_b SHALL stay constant from capture until the next grant.
REQ-027 rsp_result SHALL hold its value until the next capture.
REQ-028 Requester protocol: req and operands are held until gnt; req is dropped in the cycle after gnt.
REQ-029 A req dropped before gnt is a withdrawal and is not served.
REQ-030 The owner's req bit is ignored outside IDLE.
REQ-031 mul_done outside WAIT SHALL be ignored, with no state change.
REQ-032 A req bit rising in the same cycle as the return to IDLE SHALL compete in the next IDLE cycle.

Reset
REQ-033 While rst_n is low: state=IDLE, ptr=0, owner=0; gnt, rsp_valid, rsp_result, mul_enable, mul_a, mul_b, busy and timeout_err all 0.
REQ-034 Reset asserted mid-operation SHALL abort the operation with no response; the multiplier shares rst_n.

Configuration
REQ-035 Macro MUL_ARBITER_TIMEOUT_EN defined: a counter runs in WAIT; after TIMEOUT cycles without mul_done, pulse timeout_err, pulse rsp_valid[owner] with rsp_result=0, advance ptr, and return to IDLE.
REQ-036 Macro MUL_ARBITER_TIMEOUT_EN undefined: no counter, timeout_err is constant 0, and WAIT waits indefinitely.

Structure
REQ-037 Package mul_arbiter_pkg SHALL hold the state enum (IDLE/START/WAIT/RESP) and the default WIDTH, NREQ and TIMEOUT constants.
REQ-038 Sub-module rr_arbiter (combinational: req, ptr -> one-hot winner plus a found flag) SHALL hold the round-robin selection; the FSM stays in mul_arbiter.

Verification
REQ-039 Single request: req=4'b0001, a0=7, b0=9 -> gnt=0001; mul_enable one cycle later; rsp_valid=0001 with rsp_result=63.
REQ-040 Fairness: all four req held continuously -> grant order 0,1,2,3,0; every product correct.
REQ-041 Wrap: ptr=3 with req=4'b1001 -> requester 3 served, then requester 0.
REQ-042 Boundary: a=b=1023 (WIDTH=10) -> rsp_result=1046529; a=0 -> rsp_result=0.
REQ-043 Reset mid-WAIT -> all outputs 0; the next req is granted normally with ptr=0.
REQ-044 With MUL_ARBITER_TIMEOUT_EN: mul_done withheld -> timeout_err at cycle TIMEOUT of WAIT, rsp_valid[owner] with rsp_result=0, back to IDLE.
